// File: rtl/xsw_arb_pkg.sv
// Shared types and helpers for the xsw round-robin arbiter.
// Optional build macro used by the arbiter: XSW_RR_ARB_WEIGHT_EN.
package xsw_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Helpers operate on a fixed maximum width; callers cast in and out.
    localparam int ARB_MAXN = 64;

    function automatic logic [31:0] onehot2bin(input logic [ARB_MAXN-1:0] oh);
        logic [31:0] res;
        res = 32'd0;
        for (int i = 0; i < ARB_MAXN; i++) begin
            if (oh[i]) begin
                res = res | 32'(i);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Isolates the lowest set bit (two's-complement trick).
    function automatic logic [ARB_MAXN-1:0] ffs_lsb(input logic [ARB_MAXN-1:0] v);
        return v & (~v + ARB_MAXN'(1));
    endfunction

endpackage

// File: rtl/xsw_prefix_or.sv
// Log-depth prefix-OR network: dout[i] = OR of din[0..i].
module xsw_prefix_or #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int LV = (DW > 1) ? $clog2(DW) : 1;

    logic [DW-1:0] acc_s;
    logic [DW-1:0] nxt_s;

    // Kogge-Stone style doubling: each level ORs in the bit 2^l positions below.
    always_comb begin
        acc_s = din;
        nxt_s = din;
        for (int l = 0; l < LV; l++) begin
            nxt_s = acc_s;
            for (int i = 0; i < DW; i++) begin
                if (i >= (1 << l)) begin
                    nxt_s[i] = acc_s[i] | acc_s[i - (1 << l)];
                end else begin
                    nxt_s[i] = acc_s[i];
                end
            end
            acc_s = nxt_s;
        end
        dout = acc_s;
    end

endmodule

// File: rtl/xsw_rr_arb.sv
// Packet-aware round-robin arbiter with zero-bubble re-arbitration.
// Optional weighted service enabled by macro XSW_RR_ARB_WEIGHT_EN.
module xsw_rr_arb
    import xsw_arb_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = $clog2(N),
    parameter int WW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    last,
    input  logic            ack,
`ifdef XSW_RR_ARB_WEIGHT_EN
    input  logic [N*WW-1:0] weight,
`endif
    output logic [N-1:0]    gnt,
    output logic            gnt_vld,
    output logic [IW-1:0]   gnt_id
);

    if (N < 2 || N > ARB_MAXN || WW < 1) begin : g_bad_param
        $error("xsw_rr_arb: unsupported N/WW");
    end

    arb_state_e     state_r, state_s;
    logic [N-1:0]   gnt_r, gnt_s;
    logic [N-1:0]   pmask_r, pmask_s;
    logic           gnt_vld_r;
    logic [IW-1:0]  gnt_id_r;
    logic [N-1:0]   gpre_s;
    logic [N-1:0]   rot_s;
    logic           done_s;
    logic           rehold_s;

    function automatic logic [N-1:0] sel_f(input logic [N-1:0] r, input logic [N-1:0] m);
        if (|(r & m)) begin
            return N'(ffs_lsb(ARB_MAXN'(r & m)));
        end else begin
            return N'(ffs_lsb(ARB_MAXN'(r)));
        end
    endfunction

    xsw_prefix_or #(.DW(N)) u_prefix_or (
        .din  (gnt_r),
        .dout (gpre_s)
    );

    assign rot_s  = gpre_s << 1'b1;
    assign done_s = ack & (|(last & gnt_r));

`ifdef XSW_RR_ARB_WEIGHT_EN
    logic [WW-1:0] cnt_r, cnt_s;
    logic [WW-1:0] wk_s;
    logic [WW-1:0] weff_s;
    logic [WW:0]   cnt_inc_s;

    assign wk_s      = weight[gnt_id_r*WW +: WW];
    assign weff_s    = (wk_s == {WW{1'b0}}) ? {{(WW-1){1'b0}}, 1'b1} : wk_s;
    assign cnt_inc_s = {1'b0, cnt_r} + {{WW{1'b0}}, 1'b1};
    assign rehold_s  = (|(req & gnt_r)) & (cnt_inc_s < {1'b0, weff_s});
`else
    assign rehold_s  = 1'b0;
`endif

    // Next-state, next-grant and priority-mask update.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        pmask_s = pmask_r;
`ifdef XSW_RR_ARB_WEIGHT_EN
        cnt_s   = cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (|req) begin
                    gnt_s   = sel_f(req, pmask_r);
                    state_s = BUSY;
                end else begin
                    gnt_s   = {N{1'b0}};
                end
            end
            BUSY: begin
                if (done_s && rehold_s) begin
                    gnt_s = gnt_r;
`ifdef XSW_RR_ARB_WEIGHT_EN
                    cnt_s = cnt_inc_s[WW-1:0];
`endif
                end else if (done_s) begin
                    pmask_s = rot_s;
`ifdef XSW_RR_ARB_WEIGHT_EN
                    cnt_s   = {WW{1'b0}};
`endif
                    if (|req) begin
                        gnt_s = sel_f(req, rot_s);
                    end else begin
                        gnt_s   = {N{1'b0}};
                        state_s = IDLE;
                    end
                end else begin
                    gnt_s = gnt_r;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = {N{1'b0}};
            end
        endcase
    end

    // State, grant and registered output encodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            gnt_r     <= {N{1'b0}};
            pmask_r   <= {N{1'b1}};
            gnt_vld_r <= 1'b0;
            gnt_id_r  <= {IW{1'b0}};
`ifdef XSW_RR_ARB_WEIGHT_EN
            cnt_r     <= {WW{1'b0}};
`endif
        end else begin
            state_r   <= state_s;
            gnt_r     <= gnt_s;
            pmask_r   <= pmask_s;
            gnt_vld_r <= |gnt_s;
            gnt_id_r  <= IW'(onehot2bin(ARB_MAXN'(gnt_s)));
`ifdef XSW_RR_ARB_WEIGHT_EN
            cnt_r     <= cnt_s;
`endif
        end
    end

    assign gnt     = gnt_r;
    assign gnt_vld = gnt_vld_r;
    assign gnt_id  = gnt_id_r;

endmodule

// File: tb/tb_xsw_rr_arb.sv
// Directed self-checking bench for xsw_rr_arb with N=4.
// Weighted scenario is built when XSW_RR_ARB_WEIGHT_EN is defined.
module tb_xsw_rr_arb;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int WW = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic          ack;
    logic [N-1:0]  gnt;
    logic          gnt_vld;
    logic [IW-1:0] gnt_id;
`ifdef XSW_RR_ARB_WEIGHT_EN
    logic [N*WW-1:0] weight;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    xsw_rr_arb #(.N(N), .IW(IW), .WW(WW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .last    (last),
        .ack     (ack),
`ifdef XSW_RR_ARB_WEIGHT_EN
        .weight  (weight),
`endif
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [N-1:0] exp_gnt);
        logic [IW-1:0] exp_id;
        exp_id = 2'd0;
        for (int i = 0; i < N; i++) begin
            if (exp_gnt[i]) exp_id = IW'(i);
        end
        chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        chk({tag, ".vld"}, 32'(gnt_vld), 32'(|exp_gnt));
        chk({tag, ".id"}, 32'(gnt_id), 32'(exp_id));
    endtask

    int exp_seq [8];

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        last = 4'b0000;
        ack  = 1'b0;
`ifdef XSW_RR_ARB_WEIGHT_EN
        weight = {4'd1, 4'd1, 4'd1, 4'd3};
`endif
        tick();
        tick();
        rst = 1'b0;
        chk_grant("reset", 4'b0000);

        // 1: full request, single-beat packets
        tick();
        chk_grant("idle_before_req", 4'b0000);
        req  = 4'b1111;
        last = 4'b1111;
        ack  = 1'b1;
        tick(); chk_grant("rr0", 4'b0001);
        tick(); chk_grant("rr1", 4'b0010);
        tick(); chk_grant("rr2", 4'b0100);
        tick(); chk_grant("rr3", 4'b1000);
        tick(); chk_grant("rr4", 4'b0001);

        // 2: wrap after requester 3
        tick(); chk_grant("pre_wrap1", 4'b0010);
        tick(); chk_grant("pre_wrap2", 4'b0100);
        tick(); chk_grant("pre_wrap3", 4'b1000);
        req = 4'b0110;
        tick(); chk_grant("wrap", 4'b0010);

        // 3: packet lock on requester 2, other last bits must be ignored
        req = 4'b1111;
        tick(); chk_grant("lock_start", 4'b0100);
        last = 4'b1011;
        ack  = 1'b1;
        tick(); chk_grant("lock_beat1", 4'b0100);
        tick(); chk_grant("lock_beat2", 4'b0100);
        ack = 1'b0;
        tick(); chk_grant("lock_stall1", 4'b0100);
        tick(); chk_grant("lock_stall2", 4'b0100);
        ack = 1'b1;
        tick(); chk_grant("lock_beat3", 4'b0100);
        last = 4'b0100;
        tick(); chk_grant("lock_done", 4'b1000);

        // 4: reset mid-packet restores pmask to all ones
        ack = 1'b0;
        rst = 1'b1;
        tick(); chk_grant("mid_rst", 4'b0000);
        rst = 1'b0;
        req = 4'b1010;
        tick(); chk_grant("post_rst", 4'b0010);

        // 5: complete and idle
        req  = 4'b0000;
        last = 4'b0010;
        ack  = 1'b1;
        tick(); chk_grant("to_idle", 4'b0000);
        ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_vld", 32'(gnt_vld), 32'd0);
        end
        req = 4'b1000;
        tick(); chk_grant("one_beat", 4'b1000);
        req  = 4'b0000;
        last = 4'b1000;
        ack  = 1'b1;
        tick(); chk_grant("one_beat_done", 4'b0000);

        // 6: weighted (or pure round-robin) service between requesters 0 and 1
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
`ifdef XSW_RR_ARB_WEIGHT_EN
        exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        req  = 4'b0011;
        last = 4'b1111;
        ack  = 1'b1;
        for (int s = 0; s < 8; s++) begin
            tick();
            chk("seq_vld", 32'(gnt_vld), 32'd1);
            chk("seq_id", 32'(gnt_id), 32'(exp_seq[s]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
